shared_reg_arbiter: RTL
=======================

# shared_reg_arbiter

Round-robin arbiter and write sequencer for one shared W-bit register built from positive-edge D flip-flops. Up to N requesters compete for write access. The block grants one requester at a time, holds the grant for a bounded number of cycles, and steers the owner's data into the register while the grant is held. It sits between requesting datapath blocks and the shared storage element, and it alone drives the register's load enable and data.

## Interface
- N, default 4: number of requesters (N >= 2).
- W, default 8: register width in bits.
- HOLD, default 4: maximum GRANT cycles per ownership (HOLD >= 1).
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  N  per-requester request; bit i is requester i.
- Done  input  N  per-requester release strobe; only the owner's bit is honoured.
- D  input  N*W  flattened write data; requester i occupies bits [i*W+W-1 : i*W].
- Gnt  output  N  one-hot grant, all-zero when idle.
- Owner  output  clog2(N)  index of the current or most recent owner.
- Q  output  W  contents of the shared register.
- Timeout  output  1  one-cycle pulse when a grant is ended by the HOLD limit alone.

One clock (Clk). Reset is synchronous and active-high (Reset).

## Operation
- States: IDLE and GRANT. A registered last-owner pointer, Last, supports round-robin selection.
- Reset (sampled high at an edge):
  - State becomes IDLE.
  - Gnt=0, Q=0, Owner=0, Timeout=0.
  - Last=N-1, so requester 0 has first priority.
  - Reset overrides every other input, including in the middle of a grant.
- IDLE:
  - If Req != 0, select the first set Req bit searching (Last+1) mod N, (Last+2) mod N, … with wrap-around.
  - At the edge: Owner=selected index, Gnt=one-hot(selected), state=GRANT, cycle count c=1.
  - If Req == 0, remain in IDLE with Gnt=0.
- GRANT, cycle c (1..HOLD). At the closing edge:
  - If Req[Owner]=1, Q loads D[Owner slice]. Otherwise Q holds.
  - Release condition: Done[Owner]=1, or Req[Owner]=0, or c==HOLD.
  - On release: state=IDLE, Gnt=0, Last=Owner. Owner keeps its value.
  - Otherwise c increments and Gnt holds.
- Timeout=1 for the single cycle after a release where c==HOLD, Done[Owner]=0 and Req[Owner]=1. In every other cycle Timeout=0.
- A write and a Done in the same cycle: the write still happens (final write), then release.
- Done bits of non-owners and Req changes from non-owners during GRANT have no effect.
- There is always at least one IDLE cycle between consecutive grants. There is no back-to-back re-grant, including to a different requester.
- Q changes only in GRANT cycles with Req[Owner]=1, or on Reset.

## Timing
- Grant latency: Req sampled high in IDLE at edge k gives Gnt high from edge k, visible in cycle k+1.
- Gnt is high for between 1 and HOLD cycles inclusive. Q receives at most HOLD writes per ownership.
- Q updates at the edge ending each qualifying GRANT cycle. The new value is visible in the following cycle.
- Minimum period between grants: 1 IDLE cycle.
- With all N requesting continuously and no Done, the throughput pattern is HOLD grant cycles plus 1 idle cycle, and each requester is served once per N*(HOLD+1) cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: run arbitrary activity, assert Reset for one edge → next cycle Gnt=0000, Q=0x00, Owner=0, Timeout=0. The first request with Req=1111 grants requester 0.
- Single owner with Done (N=4, W=8, HOLD=4):
  - Stimulus: Req=0100, D slice 2 = 0xA5, Done[2] pulsed in GRANT cycle 3.
  - Response: Gnt=0100 for exactly 3 cycles, Q=0xA5, Owner=2, Timeout never asserted, Gnt=0000 in the following cycle.
- Round-robin with timeout (HOLD=2):
  - Stimulus: Req=1111 held continuously, D slices 0x11/0x22/0x33/0x44.
  - Response: grant order 0,1,2,3,0, each lasting 2 cycles with one idle cycle between. Q tracks 0x11, 0x22, 0x33, 0x44. Timeout pulses once after each grant.
- Request drop: owner 1 deasserts Req[1] in GRANT cycle 2 with D slice 1 = 0xFF → no write at that edge (Q keeps its cycle-1 value), Gnt=0000 next cycle, Timeout=0.
- Reset mid-grant: while requester 3 owns the grant with Q=0x44, Reset is asserted → next cycle Gnt=0000, Q=0x00. With Req=1001 afterwards, requester 0 is granted first.
- Foreign Done: owner 0 holds the grant while Done=0010 is pulsed → grant and writes continue unaffected until HOLD expires, followed by the Timeout pulse.

Source files
------------

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bundle for the shared register arbiter.
// master: requesters drive Req/Done/D; slave: arbiter drives Gnt/Owner/Q/Timeout.
interface shared_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int OW = $clog2(N);

  logic [N-1:0]   Req;
  logic [N-1:0]   Done;
  logic [N*W-1:0] D;
  logic [N-1:0]   Gnt;
  logic [OW-1:0]  Owner;
  logic [W-1:0]   Q;
  logic           Timeout;

  modport master (
    output Req, Done, D,
    input  Gnt, Owner, Q, Timeout
  );

  modport slave (
    input  Req, Done, D,
    output Gnt, Owner, Q, Timeout
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter + write sequencer for one shared W-bit register.
// Ports: Clk, Reset (sync, active-high), bus (slave: Req/Done/D in, Gnt/Owner/Q/Timeout out).
module shared_reg_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 4
) (
  input logic             Clk,
  input logic             Reset,
  shared_reg_arbiter_if.slave bus
);
  localparam int OW = $clog2(N);
  localparam int CW = $clog2(HOLD + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [W-1:0]  q_q, q_d;
  logic          timeout_q, timeout_d;

  logic [W-1:0]  d_arr [N];
  logic          sel_found;
  logic [OW-1:0] sel_idx;
  logic [OW-1:0] cand;
  logic          own_req;
  logic          own_done;
  logic          at_hold;
  logic          rel;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign d_arr[i] = bus.D[i*W +: W];
  end

  // First requester after the last owner, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = OW'((int'(last_q) + k) % N);
      if (!sel_found && bus.Req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign own_req  = bus.Req[owner_q];
  assign own_done = bus.Done[owner_q];
  assign at_hold  = (cnt_q == CW'(HOLD));
  assign rel      = own_done | ~own_req | at_hold;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    q_d       = q_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (sel_found) begin
          state_d = GRANT;
          owner_d = sel_idx;
          gnt_d   = N'(1) << sel_idx;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        // Final write still lands when Done arrives with Req.
        if (own_req) q_d = d_arr[owner_q];
        if (rel) begin
          state_d   = IDLE;
          gnt_d     = '0;
          last_d    = owner_q;
          timeout_d = at_hold & ~own_done & own_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= OW'(N - 1);
      gnt_q     <= '0;
      q_q       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.Gnt     = gnt_q;
  assign bus.Owner   = owner_q;
  assign bus.Q       = q_q;
  assign bus.Timeout = timeout_q;
endmodule
